// File: rtl/core_mc_pkg.sv
// core_mc_pkg: opcodes, FSM state encoding and instruction field helpers for core_mc
package core_mc_pkg;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_BR   = 4'h8;
    localparam logic [3:0] OP_BZ   = 4'h9;
    localparam logic [3:0] OP_BN   = 4'hA;
    localparam logic [3:0] OP_IN   = 4'hB;
    localparam logic [3:0] OP_OUT  = 4'hC;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_WAIT_IN, S_WAIT_OUT, S_HALT} state_t;

    // Instruction layout, MSB first: {op[3:0], isel, rid[rw-1:0], imm[dl-1:0]}
    function automatic int rid_lsb(int dl);
        return dl;
    endfunction

    function automatic int isel_bit(int dl, int rw);
        return dl + rw;
    endfunction

    function automatic int op_lsb(int dl, int rw);
        return dl + rw + 1;
    endfunction

    function automatic int ch_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/core_mc_alu.sv
// core_mc_alu: combinational accumulator ALU
//   op_i  : opcode
//   acc_i : current accumulator
//   src_i : operand (immediate or register)
//   res_o : new accumulator value (acc_i unchanged for non-ALU opcodes)
module core_mc_alu
    import core_mc_pkg::*;
#(
    parameter int DATA_LEN = 8
) (
    input  logic [3:0]          op_i,
    input  logic [DATA_LEN-1:0] acc_i,
    input  logic [DATA_LEN-1:0] src_i,
    output logic [DATA_LEN-1:0] res_o
);
    always_comb
        res_o = op_i == OP_ADD ? acc_i + src_i :
                op_i == OP_SUB ? acc_i - src_i :
                op_i == OP_AND ? acc_i & src_i :
                op_i == OP_OR  ? acc_i | src_i :
                op_i == OP_XOR ? acc_i ^ src_i :
                op_i == OP_LD  ? src_i : acc_i;
endmodule

// File: rtl/core_mc.sv
// core_mc: multi-cycle parametrised accumulator core with PROM fetch and handshaked I/O channels
//   CLK, RST    : clock, asynchronous active-high reset
//   PC          : PROM fetch address
//   INSTR       : {op, isel, rid, imm}, qualified by INSTR_VALID
//   IPORT       : N_CH input channels of DATA_LEN-1 bits, IN_VALID/IN_READY per channel
//   OPORT       : N_CH registered output channels, OUT_VALID/OUT_READY per channel
//   HALTED      : core stopped on HALT
module core_mc
    import core_mc_pkg::*;
#(
    parameter int DATA_LEN = 8,
    parameter int REG_ID_W = 2,
    parameter int PC_LEN   = 8,
    parameter int N_CH     = 2,
    localparam int INSTR_LEN = 5 + REG_ID_W + DATA_LEN
) (
    input  logic                           CLK,
    input  logic                           RST,
    output logic [PC_LEN-1:0]              PC,
    input  logic [INSTR_LEN-1:0]           INSTR,
    input  logic                           INSTR_VALID,
    input  logic [N_CH*(DATA_LEN-1)-1:0]   IPORT,
    input  logic [N_CH-1:0]                IN_VALID,
    output logic [N_CH-1:0]                IN_READY,
    output logic [N_CH*(DATA_LEN-1)-1:0]   OPORT,
    output logic [N_CH-1:0]                OUT_VALID,
    input  logic [N_CH-1:0]                OUT_READY,
    output logic                           HALTED
);
    localparam int W    = DATA_LEN - 1;
    localparam int CH_W = ch_w(N_CH);
    localparam int OP_L = op_lsb(DATA_LEN, REG_ID_W);
    localparam int SEL  = isel_bit(DATA_LEN, REG_ID_W);
    localparam int RID  = rid_lsb(DATA_LEN);

    state_t                state_q, state_d;
    logic [PC_LEN-1:0]     pc_q, pc_d;
    logic [DATA_LEN-1:0]   acc_q, acc_d;
    logic [INSTR_LEN-1:0]  ir_q, ir_d;
    logic [DATA_LEN-1:0]   regs_q [2**REG_ID_W];
    logic [DATA_LEN-1:0]   regs_d [2**REG_ID_W];
    logic [N_CH*W-1:0]     oport_q, oport_d;
    logic [N_CH-1:0]       out_valid_q, out_valid_d;

    logic [3:0]            op;
    logic [REG_ID_W-1:0]   rid;
    logic [DATA_LEN-1:0]   imm, src, alu_res;
    logic [CH_W-1:0]       ch;
    logic                  ch_ok, in_ok, ov_c;
    logic [W-1:0]          in_sel;
    logic [N_CH-1:0]       ch_hot;
    logic [PC_LEN-1:0]     pc_inc;

    assign op     = ir_q[OP_L +: 4];
    assign rid    = ir_q[RID +: REG_ID_W];
    assign imm    = ir_q[DATA_LEN-1:0];
    assign src    = ir_q[SEL] ? imm : regs_q[rid];
    assign ch     = imm[CH_W-1:0];
    assign ch_ok  = int'(ch) < N_CH;
    assign pc_inc = pc_q + PC_LEN'(1);

    core_mc_alu #(.DATA_LEN(DATA_LEN)) u_alu (
        .op_i (op),
        .acc_i(acc_q),
        .src_i(src),
        .res_o(alu_res)
    );

    // Per-channel views selected by the latched channel index
    always_comb begin
        in_sel = '0;
        in_ok  = 1'b0;
        ov_c   = 1'b0;
        ch_hot = '0;
        for (int k = 0; k < N_CH; k++)
            if (ch == CH_W'(k)) begin
                in_sel    = IPORT[k*W +: W];
                in_ok     = IN_VALID[k];
                ov_c      = out_valid_q[k];
                ch_hot[k] = 1'b1;
            end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        acc_d   = acc_q;
        ir_d    = ir_q;
        regs_d  = regs_q;
        oport_d = oport_q;
        // Accepts retire in every state; a reload below overrides the clear
        out_valid_d = out_valid_q & ~OUT_READY;
        case (state_q)
            S_FETCH: if (INSTR_VALID) begin
                ir_d    = INSTR;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                acc_d   = alu_res;
                pc_d    = pc_inc;
                state_d = S_FETCH;
                case (op)
                    OP_ST:   regs_d[rid] = acc_q;
                    OP_BR:   pc_d = imm[PC_LEN-1:0];
                    OP_BZ:   pc_d = acc_q == '0 ? imm[PC_LEN-1:0] : pc_inc;
                    OP_BN:   pc_d = acc_q[DATA_LEN-1] ? imm[PC_LEN-1:0] : pc_inc;
                    OP_IN:   if (ch_ok) begin pc_d = pc_q; state_d = S_WAIT_IN; end
                    OP_OUT:  if (ch_ok) begin pc_d = pc_q; state_d = S_WAIT_OUT; end
                    OP_HALT: begin pc_d = pc_q; state_d = S_HALT; end
                    default: ;
                endcase
            end
            S_WAIT_IN: if (in_ok) begin
                acc_d   = {in_sel[W-1], in_sel};
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_WAIT_OUT: if (!ov_c) begin
                for (int k = 0; k < N_CH; k++)
                    if (ch_hot[k]) begin
                        oport_d[k*W +: W] = acc_q[W-1:0];
                        out_valid_d[k]    = 1'b1;
                    end
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST)
        if (RST) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            acc_q       <= '0;
            ir_q        <= '0;
            regs_q      <= '{default: '0};
            oport_q     <= '0;
            out_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            acc_q       <= acc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            oport_q     <= oport_d;
            out_valid_q <= out_valid_d;
        end

    assign PC        = pc_q;
    assign OPORT     = oport_q;
    assign OUT_VALID = out_valid_q;
    assign IN_READY  = (state_q == S_WAIT_IN && in_ok) ? ch_hot : '0;
    assign HALTED    = state_q == S_HALT;
endmodule

// File: tb/tb_core_mc.sv
// tb_core_mc: scoreboard bench for core_mc driven by an instruction-level reference model
module tb_core_mc;
    localparam int DL = 8, RW = 2, PL = 8, NC = 2, IL = 5 + RW + DL, W = DL - 1;

    logic CLK = 1'b0, RST = 1'b1;
    logic [PL-1:0] PC;
    logic [IL-1:0] INSTR;
    logic INSTR_VALID, HALTED;
    logic [NC*W-1:0] IPORT, OPORT;
    logic [NC-1:0] IN_VALID, IN_READY, OUT_VALID, OUT_READY;

    logic [IL-1:0] rom [256];
    logic [W-1:0]  in_val [NC];
    logic rnd = 1'b0, dir_iv = 1'b1, rnd_iv = 1'b1;
    logic [NC-1:0] dir_ivalid = '0, dir_ready = '0, rnd_ivalid = '0, rnd_ready = '0;

    int n_chk = 0, n_fail = 0, n_in_seen = 0, exp_hpc, exp_nin, mon_e;
    logic [PL-1:0] last_pc = '0;
    int pcq[$];
    int oq0[$];
    int oq1[$];

    assign INSTR       = rom[PC];
    assign INSTR_VALID = rnd ? rnd_iv : dir_iv;
    assign IN_VALID    = rnd ? rnd_ivalid : dir_ivalid;
    assign OUT_READY   = rnd ? rnd_ready : dir_ready;
    assign IPORT       = {in_val[1], in_val[0]};

    always #5 CLK = ~CLK;

    core_mc dut (
        .CLK(CLK), .RST(RST), .PC(PC), .INSTR(INSTR), .INSTR_VALID(INSTR_VALID),
        .IPORT(IPORT), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OPORT(OPORT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .HALTED(HALTED)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [IL-1:0] ins(input int op, input int isel, input int rid, input int imm);
        return {4'(op), 1'(isel), 2'(rid), 8'(imm)};
    endfunction

    task automatic clear_rom();
        for (int a = 0; a < 256; a++) rom[a] = ins(15, 0, 0, 0);
    endtask

    // Instruction-set reference: runs the ROM to HALT, recording every PC change,
    // every OUT value per channel and the number of IN transfers.
    task automatic model(output int hpc, output int nin);
        int pc = 0, acc = 0, src, npc, op, imm, v;
        int r[4] = '{default: 0};
        nin = 0;
        hpc = -1;
        for (int s = 0; s < 5000; s++) begin
            op  = int'(rom[pc][14:11]);
            imm = int'(rom[pc][7:0]);
            src = rom[pc][10] ? imm : r[int'(rom[pc][9:8])];
            npc = (pc + 1) % 256;
            case (op)
                1: acc = (acc + src) % 256;
                2: acc = (acc - src + 256) % 256;
                3: acc = acc & src;
                4: acc = acc | src;
                5: acc = acc ^ src;
                6: acc = src;
                7: r[int'(rom[pc][9:8])] = acc;
                8: npc = imm;
                9: if (acc == 0) npc = imm;
                10: if (acc >= 128) npc = imm;
                11: begin
                    v = int'(in_val[imm % 2]);
                    acc = v >= 64 ? v + 128 : v;
                    nin++;
                end
                12: if (imm % 2 == 0) oq0.push_back(acc % 128); else oq1.push_back(acc % 128);
                15: begin hpc = pc; return; end
                default: ;
            endcase
            if (npc != pc) pcq.push_back(npc);
            pc = npc;
        end
    endtask

    always @(posedge CLK) begin
        #1;
        rnd_iv     = $urandom_range(0, 3) != 0;
        rnd_ivalid = NC'($urandom);
        rnd_ready  = NC'($urandom);
    end

    always @(negedge CLK) begin
        if (RST) last_pc = '0;
        else begin
            if (PC != last_pc) begin
                mon_e = pcq.size() > 0 ? pcq.pop_front() : -1;
                chk("pc_trace", int'(PC), mon_e);
                last_pc = PC;
            end
            if (OUT_VALID[0] && OUT_READY[0]) begin
                mon_e = oq0.size() > 0 ? oq0.pop_front() : -1;
                chk("out_ch0", int'(OPORT[W-1:0]), mon_e);
            end
            if (OUT_VALID[1] && OUT_READY[1]) begin
                mon_e = oq1.size() > 0 ? oq1.pop_front() : -1;
                chk("out_ch1", int'(OPORT[2*W-1:W]), mon_e);
            end
            if (IN_READY != '0) begin
                n_in_seen++;
                chk("in_ready_legal", int'((IN_READY & ~IN_VALID) == '0 && $onehot(IN_READY)), 1);
            end
        end
    end

    task automatic start();
        @(posedge CLK);
        #1 RST = 1'b1;
        pcq.delete();
        oq0.delete();
        oq1.delete();
        n_in_seen = 0;
        model(exp_hpc, exp_nin);
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic finish_run();
        for (int i = 0; i < 3000 && !HALTED; i++) @(negedge CLK);
        @(posedge CLK);
        #1;
        rnd = 1'b0;
        dir_iv = 1'b1;
        dir_ready = '1;
        repeat (6) @(negedge CLK);
        chk("halted", int'(HALTED), 1);
        chk("halt_pc", int'(PC), exp_hpc);
        chk("pc_trace_left", pcq.size(), 0);
        chk("out_left", oq0.size() + oq1.size(), 0);
        chk("in_count", n_in_seen, exp_nin);
    endtask

    task automatic prog_alu();
        clear_rom();
        rom[0] = ins(6, 1, 0, 5);
        rom[1] = ins(1, 1, 0, 3);
        rom[2] = ins(2, 1, 0, 1);
        rom[3] = ins(5, 1, 0, 8'hFF);
        rom[4] = ins(7, 0, 1, 0);
        rom[5] = ins(6, 0, 1, 0);
        rom[6] = ins(12, 1, 0, 0);
    endtask

    initial begin
        in_val[0] = '0;
        in_val[1] = '0;
        clear_rom();
        #3;
        chk("rst_pc", int'(PC), 0);
        chk("rst_out_valid", int'(OUT_VALID), 0);
        chk("rst_in_ready", int'(IN_READY), 0);
        chk("rst_halted", int'(HALTED), 0);
        chk("rst_oport", int'(OPORT), 0);

        // ALU chain: ACC ends at 0xF8, OUT ch0 shows 0x78
        prog_alu();
        dir_ready = '1;
        start();
        repeat (12) @(posedge CLK);
        #1 chk("pc_after_12", int'(PC), 6);
        finish_run();

        // Fetch stall at PC=2
        start();
        for (int i = 0; i < 50 && PC != 2; i++) begin @(posedge CLK); #1; end
        dir_iv = 1'b0;
        repeat (4) @(posedge CLK);
        #1 chk("fetch_stall_pc", int'(PC), 2);
        dir_iv = 1'b1;
        finish_run();

        // Branches: BZ taken, BN taken, BZ not taken, BR 0xFF wrapping to 0
        clear_rom();
        rom[0]     = ins(6, 0, 2, 0);
        rom[1]     = ins(9, 1, 0, 8'h10);
        rom[2]     = ins(12, 1, 0, 0);
        rom[8'h10] = ins(6, 1, 0, 8'h80);
        rom[8'h11] = ins(10, 1, 0, 8'h20);
        rom[8'h20] = ins(6, 1, 0, 1);
        rom[8'h21] = ins(9, 1, 0, 8'h10);
        rom[8'h22] = ins(7, 0, 2, 0);
        rom[8'h23] = ins(8, 1, 0, 8'hFF);
        rom[8'hFF] = ins(0, 0, 0, 0);
        start();
        finish_run();
        repeat (10) @(negedge CLK);
        chk("halt_frozen_pc", int'(PC), exp_hpc);
        chk("halt_frozen", int'(HALTED), 1);

        // IN ch1 with valid 3+ cycles late, sign-extended into ACC
        clear_rom();
        rom[0]     = ins(11, 1, 0, 1);
        rom[1]     = ins(10, 1, 0, 8'h10);
        rom[8'h10] = ins(12, 1, 0, 1);
        in_val[1]  = 7'h7E;
        dir_ivalid = '0;
        start();
        repeat (5) @(posedge CLK);
        #1;
        chk("in_wait_ready", int'(IN_READY), 0);
        chk("in_wait_pc", int'(PC), 0);
        dir_ivalid = 2'b10;
        @(negedge CLK);
        chk("in_ready_pulse", int'(IN_READY), 2);
        @(negedge CLK);
        chk("in_ready_after", int'(IN_READY), 0);
        finish_run();

        // OUT backpressure on ch0
        clear_rom();
        rom[0] = ins(6, 1, 0, 8'h35);
        rom[1] = ins(12, 1, 0, 0);
        rom[2] = ins(6, 1, 0, 8'h12);
        rom[3] = ins(12, 1, 0, 0);
        dir_ready = '0;
        start();
        repeat (20) @(posedge CLK);
        #1;
        chk("bp_oport_first", int'(OPORT[W-1:0]), 8'h35);
        chk("bp_valid_first", int'(OUT_VALID), 1);
        chk("bp_stall_pc", int'(PC), 3);
        chk("bp_not_halted", int'(HALTED), 0);
        dir_ready = 2'b01;
        @(posedge CLK);
        #1 dir_ready = '0;
        @(posedge CLK);
        #1;
        chk("bp_oport_second", int'(OPORT[W-1:0]), 8'h12);
        chk("bp_valid_second", int'(OUT_VALID), 1);
        chk("bp_pc_second", int'(PC), 4);
        finish_run();

        // Reset while stalled in WAIT_IN with an OUT still pending
        clear_rom();
        rom[0] = ins(6, 1, 0, 5);
        rom[1] = ins(12, 1, 0, 1);
        rom[2] = ins(11, 1, 0, 0);
        dir_ready  = '0;
        dir_ivalid = '0;
        start();
        repeat (12) @(posedge CLK);
        #1 chk("pre_rst_valid", int'(OUT_VALID), 2);
        #1 RST = 1'b1;
        #1;
        chk("mid_rst_pc", int'(PC), 0);
        chk("mid_rst_out_valid", int'(OUT_VALID), 0);
        chk("mid_rst_oport", int'(OPORT), 0);
        chk("mid_rst_in_ready", int'(IN_READY), 0);
        chk("mid_rst_halted", int'(HALTED), 0);

        // Random forward-branching programs under random handshakes and fetch stalls
        for (int t = 0; t < 8; t++) begin
            clear_rom();
            for (int a = 0; a < 40; a++) begin
                int op, imm;
                op  = $urandom_range(0, 14);
                imm = (op >= 8 && op <= 10) ? $urandom_range(a + 1, 40) : $urandom_range(0, 255);
                rom[a] = ins(op, $urandom_range(0, 1), $urandom_range(0, 3), imm);
            end
            in_val[0] = W'($urandom);
            in_val[1] = W'($urandom);
            rnd = 1'b1;
            start();
            finish_run();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
